// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// TXSTAT bit layout and the address-decode selector type.
package dmem_pkg;

   // Word offsets from MMIO_BASE
   localparam int LED_OFS    = 0;
   localparam int CYCLE_OFS  = 1;
   localparam int TXDATA_OFS = 2;
   localparam int TXSTAT_OFS = 3;

   // TXSTAT bit positions
   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_CNT_LO = 3;
   localparam int ST_CNT_HI = 5;

   // Which target the current word address selects
   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_CYCLE,
      SEL_TXDATA,
      SEL_TXSTAT
   } sel_e;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte TX FIFO behind the TXDATA register. State changes on the falling
// clock edge, like the rest of the responder. The head byte is held in its
// own register so tx_data is a clean flop output with a defined reset value.
import dmem_pkg::*;

module tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = $clog2(FIFO_DEPTH),
   parameter int CNT_W      = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [7:0]       din_i,
   input  logic             pop_i,
   input  logic             ovf_clr_i,
   output logic [7:0]       head_o,
   output logic             valid_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o,
   output logic             ovf_o
);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [PTR_W-1:0] rd_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       head_q;
   logic [7:0]       head_d;
   logic             ovf_q;
   logic             do_push;
   logic             do_pop;

   // full/empty come from the pre-edge count; a push into a full FIFO is
   // dropped even when a pop frees a slot at the same edge
   assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next read pointer, occupancy and head byte; a byte pushed into an
   // empty slot that becomes the head is forwarded from din_i
   always_comb begin
      rd_d   = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d  = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      head_d = mem_q[rd_d];
      if (cnt_d == '0) begin
         head_d = '0;
      end else if (do_push && (wr_q == rd_d)) begin
         head_d = din_i;
      end
   end

   // Storage array: data only, no reset
   always_ff @(negedge clock) begin
      if (do_push) begin
         mem_q[wr_q] <= din_i;
      end
   end

   // Pointers, count, head register and sticky overflow flag
   always_ff @(negedge clock) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + 1'b1;
         end
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         if (push_i && full_o) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign head_o  = head_q;
   assign valid_o = !empty_o;
   assign count_o = cnt_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the processor data-memory port. Word addresses below
// DEPTH hit RAM; four MMIO registers at MMIO_BASE provide LEDs, a cycle
// counter and a byte TX stream. Every other address reads 0 and ignores
// writes. Updates happen on the falling edge so q_dmem is settled before
// the processor's next rising edge.
import dmem_pkg::*;

module dmem_responder #(
   parameter int          DEPTH      = 4096,
   parameter int          ADDR_W     = 12,
   parameter int          LED_W      = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'h1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   input  logic              wren,
   output logic [31:0]       q_dmem,
   output logic [LED_W-1:0]  led_out,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   sel_e              sel;
   logic [ADDR_W-1:0] ram_idx;
   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       q_q;
   logic [31:0]       q_d;
   logic [LED_W-1:0]  led_q;
   logic [31:0]       cyc_q;
   logic [31:0]       cyc_d;
   logic [31:0]       stat;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_ovf;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              wr_led;
   logic              wr_cyc;
   logic              wr_txdata;
   logic              wr_txstat;

   // The TXSTAT count field is 3 bits wide; clamp larger counts
   function automatic logic [2:0] cnt_sat(input logic [CNT_W-1:0] c);
      logic [31:0] c32;
      c32 = 32'(c);
      if (c32 > 32'd7) begin
         return 3'd7;
      end
      return c32[2:0];
   endfunction

   // Full 32-bit address decode so upper address bits never alias
   always_comb begin
      sel = SEL_NONE;
      if (address_dmem < 32'(DEPTH)) begin
         sel = SEL_RAM;
      end else if (address_dmem == MMIO_BASE + 32'(LED_OFS)) begin
         sel = SEL_LED;
      end else if (address_dmem == MMIO_BASE + 32'(CYCLE_OFS)) begin
         sel = SEL_CYCLE;
      end else if (address_dmem == MMIO_BASE + 32'(TXDATA_OFS)) begin
         sel = SEL_TXDATA;
      end else if (address_dmem == MMIO_BASE + 32'(TXSTAT_OFS)) begin
         sel = SEL_TXSTAT;
      end
   end

   assign ram_idx   = address_dmem[ADDR_W-1:0];
   assign wr_led    = wren && (sel == SEL_LED);
   assign wr_cyc    = wren && (sel == SEL_CYCLE);
   assign wr_txdata = wren && (sel == SEL_TXDATA);
   assign wr_txstat = wren && (sel == SEL_TXSTAT);

   // TXSTAT word assembled from the pre-edge FIFO state
   always_comb begin
      stat                       = '0;
      stat[ST_FULL]              = fifo_full;
      stat[ST_EMPTY]             = fifo_empty;
      stat[ST_OVF]               = fifo_ovf;
      stat[ST_CNT_HI:ST_CNT_LO]  = cnt_sat(fifo_cnt);
   end

   // Load mux; all sources are pre-edge values, giving read-before-write
   always_comb begin
      case (sel)
         SEL_RAM:    q_d = mem_q[ram_idx];
         SEL_LED:    q_d = 32'(led_q);
         SEL_CYCLE:  q_d = cyc_q;
         SEL_TXSTAT: q_d = stat;
         default:    q_d = '0;
      endcase
   end

   // A write to CYCLE clears it and takes priority over the increment
   always_comb begin
      cyc_d = cyc_q + 32'd1;
      if (wr_cyc) begin
         cyc_d = '0;
      end
   end

   // RAM array: contents survive reset, stores on the reset edge are dropped
   always_ff @(negedge clock) begin
      if (!reset && wren && (sel == SEL_RAM)) begin
         mem_q[ram_idx] <= data;
      end
   end

   // Load data, LED and cycle-counter registers
   always_ff @(negedge clock) begin
      if (reset) begin
         q_q   <= '0;
         led_q <= '0;
         cyc_q <= '0;
      end else begin
         q_q   <= q_d;
         cyc_q <= cyc_d;
         if (wr_led) begin
            led_q <= data[LED_W-1:0];
         end
      end
   end

   tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_i    (wr_txdata),
      .din_i     (data[7:0]),
      .pop_i     (tx_valid && tx_ready),
      .ovf_clr_i (wr_txstat),
      .head_o    (tx_data),
      .valid_o   (tx_valid),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt),
      .ovf_o     (fifo_ovf)
   );

   assign q_dmem  = q_q;
   assign led_out = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by random traffic,
// all compared against a behavioural model built from the address map rules
// (RAM shadow array, byte queue for the TX FIFO, plain counters).
module tb_dmem_responder;

   localparam int          DEPTH = 4096;
   localparam int          FD    = 4;
   localparam logic [31:0] A     = 32'h1000;

   logic        clock;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [7:0]  led_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int errs   = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_ram   [DEPTH];
   bit          m_known [DEPTH];
   logic [7:0]  m_fifo  [$];
   bit          m_ovf;
   logic [7:0]  m_led;
   logic [31:0] m_cyc;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .led_out      (led_out),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One processor cycle: drive after the rising edge, let the responder
   // act on the falling edge, then compare against the model
   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic r, input logic rdy);
      logic [31:0] qe;
      bit          qk;
      bit          full;
      int          n;
      @(posedge clock);
      #1;
      address_dmem = a;
      data         = d;
      wren         = w;
      reset        = r;
      tx_ready     = rdy;
      qe = 32'h0;
      qk = 1'b1;
      if (r) begin
         m_led = 8'h0;
         m_cyc = 32'h0;
         m_fifo.delete();
         m_ovf = 1'b0;
      end else begin
         n = m_fifo.size();
         if (a < DEPTH) begin
            qk = m_known[a[11:0]];
            qe = m_ram[a[11:0]];
         end else if (a == A) begin
            qe = {24'h0, m_led};
         end else if (a == A + 1) begin
            qe = m_cyc;
         end else if (a == A + 3) begin
            qe = {26'h0, (n > 7) ? 3'd7 : 3'(n), m_ovf, n == 0, n == FD};
         end
         full = (n == FD);
         if (rdy && n > 0) void'(m_fifo.pop_front());
         if (w && a == A + 2) begin
            if (full) m_ovf = 1'b1;
            else      m_fifo.push_back(d[7:0]);
         end
         if (w && a == A + 3) m_ovf = 1'b0;
         m_cyc = (w && a == A + 1) ? 32'h0 : m_cyc + 32'd1;
         if (w && a == A) m_led = d[7:0];
         if (w && a < DEPTH) begin
            m_ram[a[11:0]]   = d;
            m_known[a[11:0]] = 1'b1;
         end
      end
      @(negedge clock);
      #1;
      if (qk) chk("q_dmem", q_dmem, qe);
      chk("led_out", 32'(led_out), 32'(m_led));
      chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) chk("tx_data", 32'(tx_data), 32'(m_fifo[0]));
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return 32'($urandom_range(0, 15));
         4:          return 32'd4095;
         5, 6:       return A + 2;
         7:          return A + 3;
         8:          return A + 32'($urandom_range(0, 1));
         default: begin
            case ($urandom_range(0, 3))
               0:       return A + 4;
               1:       return 32'h0001_0000;
               2:       return 32'h0001_0005;
               default: return $urandom;
            endcase
         end
      endcase
   endfunction

   initial begin
      address_dmem = 32'h0;
      data         = 32'h0;
      wren         = 1'b0;
      reset        = 1'b1;
      tx_ready     = 1'b0;
      m_led        = 8'h0;
      m_cyc        = 32'h0;
      m_ovf        = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         m_known[i] = 1'b0;
         m_ram[i]   = 32'h0;
      end

      // Reset state
      step(A + 4, 0, 0, 1, 0);
      step(A + 4, 0, 0, 1, 0);
      chk("rst_q", q_dmem, 32'h0);
      chk("rst_led", 32'(led_out), 32'h0);
      chk("rst_valid", 32'(tx_valid), 32'h0);
      chk("rst_txdata", 32'(tx_data), 32'h0);

      // RAM store/load and read-before-write
      step(5, 32'hDEADBEEF, 1, 0, 0);
      step(5, 0, 0, 0, 0);
      chk("ram_load", q_dmem, 32'hDEADBEEF);
      step(5, 32'h1, 1, 0, 0);
      chk("ram_rbw", q_dmem, 32'hDEADBEEF);
      step(5, 0, 0, 0, 0);
      chk("ram_new", q_dmem, 32'h1);

      // Cycle counter
      step(A + 4, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(A + 4, 0, 0, 0, 0);
      step(A + 1, 0, 0, 0, 0);
      chk("cycle10", q_dmem, 32'd10);
      step(A + 1, 32'h1234, 1, 0, 0);
      step(A + 1, 0, 0, 0, 0);
      chk("cycle_clr", q_dmem, 32'h0);

      // FIFO fill, overflow, drain, ovf clear
      for (int i = 0; i < 5; i++) step(A + 2, 32'h41 + i, 1, 0, 0);
      step(A + 3, 0, 0, 0, 0);
      chk("stat_full", q_dmem, 32'h25);
      for (int i = 0; i < 4; i++) begin
         chk("drain_byte", 32'(tx_data), 32'h41 + i);
         step(A + 4, 0, 0, 0, 1);
      end
      chk("drain_empty", 32'(tx_valid), 32'h0);
      step(A + 3, 0, 0, 0, 1);
      chk("stat_ovf", q_dmem, 32'h06);
      step(A + 3, 0, 1, 0, 0);
      step(A + 3, 0, 0, 0, 0);
      chk("stat_clr", q_dmem, 32'h02);

      // Simultaneous push/pop, then push+pop while full
      step(A + 2, 32'h50, 1, 0, 0);
      step(A + 2, 32'h51, 1, 0, 0);
      step(A + 2, 32'h55, 1, 0, 1);
      step(A + 3, 0, 0, 0, 0);
      chk("stat_cnt2", q_dmem, 32'h10);
      step(A + 2, 32'h56, 1, 0, 0);
      step(A + 2, 32'h57, 1, 0, 0);
      step(A + 2, 32'h58, 1, 0, 1);
      step(A + 3, 0, 0, 0, 0);
      chk("stat_drop", q_dmem, 32'h1C);
      chk("head_after_drop", 32'(tx_data), 32'h55);

      // LED register and unmapped addresses
      step(A, 32'h1FF, 1, 0, 0);
      chk("led_wr", 32'(led_out), 32'hFF);
      step(A, 0, 0, 0, 0);
      chk("led_rd", q_dmem, 32'hFF);
      step(32'h0001_0000, 0, 0, 0, 0);
      chk("unmapped_rd", q_dmem, 32'h0);
      step(0, 32'h12345678, 1, 0, 0);
      step(32'h0001_0000, 32'hCAFE, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("no_alias_ram", q_dmem, 32'h12345678);
      chk("no_alias_led", 32'(led_out), 32'hFF);

      // Stores suppressed on the reset edge; queued bytes discarded
      step(7, 32'hAAAA, 1, 0, 0);
      step(7, 32'h5555, 1, 1, 0);
      step(A + 2, 32'h77, 1, 1, 1);
      step(A, 32'h3C, 1, 1, 0);
      step(7, 0, 0, 0, 0);
      chk("rst_store_ram", q_dmem, 32'hAAAA);
      chk("rst_store_fifo", 32'(tx_valid), 32'h0);
      chk("rst_store_led", 32'(led_out), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(rand_addr(), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
